// File: rtl/keepalive_gen.sv
// keepalive_gen: heartbeat requester that keeps a remote timeout watchdog fed.
// Every `period` cycles it raises hb_req for up to `ack_window` cycles. If no
// acknowledge arrives it retries MAX_RETRY times, then raises a sticky hb_fail.
// Optional build macro HB_MISS_CNT_EN adds an 8-bit saturating miss counter
// (miss_cnt) that is cleared only by reset.
//
// Request/acknowledge protocol: hb_req is a level held high for the whole
// acknowledge window. hb_ack is sampled only on edges where the generator is
// waiting (hb_req high). One sampled hb_ack ends the attempt. An ack and a
// window timeout on the same edge count as an ack. hb_ack at any other time
// is ignored and is not remembered.
module keepalive_gen #(
  parameter int CNT_W     = 32,
  parameter int MAX_RETRY = 3,
  parameter int RETRY_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   ack_window,
  input  logic               hb_ack,
  output logic               hb_req,
  output logic               hb_busy,
  output logic               hb_fail,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef HB_MISS_CNT_EN
  ,
  output logic [7:0]         miss_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COUNT    = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_FAIL     = 3'd4
  } state_t;

  // state_q is the debug view of the FSM for checkers bound to this module.
  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [RETRY_W-1:0] retry_d;
  logic [CNT_W-1:0]   period_lim;
  logic [CNT_W-1:0]   ack_lim;
  logic [CNT_W-1:0]   cnt_inc;
  logic               count_done;
  logic               window_done;

  // Terminal counts, max(x,1)-1, taken live from the inputs every cycle.
  assign period_lim  = (period == '0) ? '0 : period - CNT_W'(1);
  assign ack_lim     = (ack_window == '0) ? '0 : ack_window - CNT_W'(1);
  // Saturating increment: the counter parks at all-ones instead of wrapping.
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign count_done  = (cnt_q >= period_lim);
  assign window_done = (cnt_q >= ack_lim);

  // Next-state, counter and retry logic; en low overrides every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_cnt;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          retry_d = '0;
          state_d = ST_COUNT;
        end
        ST_COUNT: begin
          cnt_d = cnt_inc;
          if (count_done) begin
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_d   = '0;
          state_d = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (hb_ack) begin
            cnt_d   = '0;
            retry_d = '0;
            state_d = ST_COUNT;
          end else if (window_done) begin
            cnt_d = '0;
            if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_cnt + RETRY_W'(1);
              state_d = ST_ISSUE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_FAIL: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs; outputs are decoded from the next
  // state so they change on the same edge as the transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      retry_cnt <= '0;
      hb_req    <= 1'b0;
      hb_busy   <= 1'b0;
      hb_fail   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_cnt <= retry_d;
      hb_req    <= (state_d == ST_WAIT_ACK);
      hb_busy   <= (state_d == ST_ISSUE) || (state_d == ST_WAIT_ACK);
      hb_fail   <= (state_d == ST_FAIL);
    end
  end

`ifdef HB_MISS_CNT_EN
  logic miss_ev;

  // A miss is a window timeout without ack while enabled, whether it leads to
  // a retry or to FAIL.
  assign miss_ev = en && (state_q == ST_WAIT_ACK) && !hb_ack && window_done;

  // Saturating miss counter; survives en=0 and clears only on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_cnt <= 8'd0;
    end else if (miss_ev && (miss_cnt != 8'hFF)) begin
      miss_cnt <= miss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_keepalive_gen.sv
// Bench for keepalive_gen: a phase/countdown reference model predicts outputs
// per edge into an expected queue, compared on the falling edge.
`timescale 1ns/100ps
module tb_keepalive_gen;

  localparam int CNT_W     = 32;
  localparam int MAX_RETRY = 3;
  localparam int RETRY_W   = 2;

  localparam int P_IDLE  = 0;
  localparam int P_COUNT = 1;
  localparam int P_ISSUE = 2;
  localparam int P_WAIT  = 3;
  localparam int P_FAIL  = 4;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0;
  logic               hb_ack = 1'b0;
  logic [CNT_W-1:0]   period = '0;
  logic [CNT_W-1:0]   ack_window = '0;
  logic               hb_req;
  logic               hb_busy;
  logic               hb_fail;
  logic [RETRY_W-1:0] retry_cnt;

  always #12.5 clk = ~clk;

`ifdef HB_MISS_CNT_EN
  logic [7:0] miss_cnt;
  keepalive_gen #(.CNT_W(CNT_W), .MAX_RETRY(MAX_RETRY), .RETRY_W(RETRY_W)) dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .ack_window(ack_window),
    .hb_ack(hb_ack), .hb_req(hb_req), .hb_busy(hb_busy), .hb_fail(hb_fail),
    .retry_cnt(retry_cnt), .miss_cnt(miss_cnt)
  );
`else
  keepalive_gen #(.CNT_W(CNT_W), .MAX_RETRY(MAX_RETRY), .RETRY_W(RETRY_W)) dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .ack_window(ack_window),
    .hb_ack(hb_ack), .hb_req(hb_req), .hb_busy(hb_busy), .hb_fail(hb_fail),
    .retry_cnt(retry_cnt)
  );
`endif

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase plus cycles-left countdown; attempts counted as retries used.
  int m_phase = P_IDLE;
  int m_left  = 0;
  int m_try   = 0;
  int m_miss  = 0;

  task automatic model_reset();
    m_phase = P_IDLE;
    m_left  = 0;
    m_try   = 0;
    m_miss  = 0;
  endtask

  task automatic model_edge(input logic en_v, input logic ack_v);
    int pe;
    int we;
    pe = (period == 0) ? 1 : int'(period);
    we = (ack_window == 0) ? 1 : int'(ack_window);
    if (!en_v) begin
      m_phase = P_IDLE;
      m_try   = 0;
      m_left  = 0;
      return;
    end
    case (m_phase)
      P_IDLE: begin
        m_phase = P_COUNT;
        m_left  = pe;
      end
      P_COUNT: begin
        m_left--;
        if (m_left == 0) m_phase = P_ISSUE;
      end
      P_ISSUE: begin
        m_phase = P_WAIT;
        m_left  = we;
      end
      P_WAIT: begin
        if (ack_v) begin
          m_phase = P_COUNT;
          m_left  = pe;
          m_try   = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            if (m_miss < 255) m_miss++;
            if (m_try == MAX_RETRY) begin
              m_phase = P_FAIL;
            end else begin
              m_try++;
              m_phase = P_ISSUE;
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [12:0] model_out();
    logic [12:0] v;
    v[12]  = (m_phase == P_WAIT);
    v[11]  = (m_phase == P_ISSUE) || (m_phase == P_WAIT);
    v[10]  = (m_phase == P_FAIL);
    v[9:8] = 2'(m_try);
    v[7:0] = 8'(m_miss);
    return v;
  endfunction

  task automatic compare_outputs(input logic [12:0] e);
    check_eq("hb_req", {31'd0, hb_req}, {31'd0, e[12]});
    check_eq("hb_busy", {31'd0, hb_busy}, {31'd0, e[11]});
    check_eq("hb_fail", {31'd0, hb_fail}, {31'd0, e[10]});
    check_eq("retry_cnt", {30'd0, retry_cnt}, {30'd0, e[9:8]});
`ifdef HB_MISS_CNT_EN
    check_eq("miss_cnt", {24'd0, miss_cnt}, {24'd0, e[7:0]});
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: apply inputs, predict the next edge, check after it.
  task automatic cycle(input logic en_v, input logic ack_v);
    logic [12:0] e;
    en     = en_v;
    hb_ack = ack_v;
    model_edge(en_v, ack_v);
    exp_q.push_back(model_out());
    @(negedge clk);
    e = exp_q.pop_front();
    compare_outputs(e);
  endtask

  // mode 0: never ack, 1: always ack, 2: random ack, 3: ack on the last
  // window cycle of the second attempt
  function automatic logic pick_ack(input int mode);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return ($urandom_range(0, 99) < 30);
      default: return (m_phase == P_WAIT) && (m_try == 1) && (m_left == 1);
    endcase
  endfunction

  // One en=0 edge, then n enabled edges with the given parameters.
  task automatic run_seg(input int p, input int w, input int n, input int mode,
                         input bit chk_lat, input int exp_highs, input int exp_max_retry);
    int first;
    int highs;
    int max_retry;
    period     = CNT_W'(p);
    ack_window = CNT_W'(w);
    cycle(1'b0, 1'b0);
    first     = -1;
    highs     = 0;
    max_retry = 0;
    for (int i = 1; i <= n; i++) begin
      cycle(1'b1, pick_ack(mode));
      if (hb_req && first < 0) first = i;
      if (hb_req) highs++;
      if (int'(retry_cnt) > max_retry) max_retry = int'(retry_cnt);
    end
    if (chk_lat) check_eq("first_req_latency", first, ((p == 0) ? 1 : p) + 2);
    if (exp_highs >= 0) check_eq("req_high_cycles", highs, exp_highs);
    if (exp_max_retry >= 0) check_eq("max_retry_seen", max_retry, exp_max_retry);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_req", {31'd0, hb_req}, 0);
    check_eq("reset_busy", {31'd0, hb_busy}, 0);
    check_eq("reset_fail", {31'd0, hb_fail}, 0);
    check_eq("reset_retry", {30'd0, retry_cnt}, 0);
`ifdef HB_MISS_CNT_EN
    check_eq("reset_miss", {24'd0, miss_cnt}, 0);
`endif
    rst = 1'b1;

    // ack always present: one high cycle every 6
    run_seg(4, 3, 20, 1, 1'b1, 3, 0);
    // no ack: 4 windows of 3 high cycles, then FAIL
    run_seg(4, 3, 30, 0, 1'b1, 12, 3);
    // leave FAIL via en=0; ack on the last cycle of attempt 2 every time
    run_seg(4, 3, 40, 3, 1'b1, -1, 1);
    check_eq("ack_last_no_fail", {31'd0, hb_fail}, 0);
    // zero period/window behave as 1: 1 high / 1 low, four attempts
    run_seg(0, 0, 12, 0, 1'b1, 4, 3);

    // asynchronous reset while hb_req is high
    period     = CNT_W'(1);
    ack_window = CNT_W'(5);
    cycle(1'b0, 1'b0);
    begin
      int guard;
      guard = 0;
      while (!hb_req && guard < 20) begin
        cycle(1'b1, 1'b0);
        guard++;
      end
      if (!hb_req) check_eq("reach_wait_ack", 0, 1);
    end
    #4;
    rst = 1'b0;
    #1;
    check_eq("async_rst_req", {31'd0, hb_req}, 0);
    check_eq("async_rst_busy", {31'd0, hb_busy}, 0);
    check_eq("async_rst_fail", {31'd0, hb_fail}, 0);
    check_eq("async_rst_retry", {30'd0, retry_cnt}, 0);
`ifdef HB_MISS_CNT_EN
    check_eq("async_rst_miss", {24'd0, miss_cnt}, 0);
`endif
    model_reset();
    en     = 1'b0;
    hb_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // randomized segments
    for (int s = 0; s < 24; s++) begin
      run_seg($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(5, 40),
              $urandom_range(0, 3), 1'b0, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

endmodule
